pc_unit: RTL and testbench

- Parametrised program-counter unit for the IF stage.
- Generalises the single-width PC register with a configurable width, reset vector and instruction step.
- Adds a RUN/HALT state machine, stall hold, prioritised redirects (trap, branch, return) and a circular return-address stack (RAS) for call/return prediction.
- Drives the fetch address to the instruction ROM and the PC forwarded to ID.

---
 rtl/pc_unit.sv | 142 ++++++++++++++
 tb/tb_pc_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with RUN/HALT control, stall hold,
// prioritised redirects (trap > branch > return) and a circular
// return-address stack for call/return prediction.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, halt     level controls for the IDLE/RUN/HALT state machine
//   stall           hold pc this cycle (hazard)
//   branch          redirect to branch_address
//   trap            redirect to trap_vector (highest priority)
//   call, ret       current fetch is a call / return (RAS push / pop)
//   pc              registered fetch address
//   pc_valid        pc is a valid fetch this cycle
//   ras_empty       RAS holds no entries
//   ras_full        RAS holds RAS_DEPTH entries
module pc_unit #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int unsigned       INSTR_BYTES  = 4,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt,
  input  logic            stall,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_address,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0]  STEP    = XLEN'(INSTR_BYTES);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  pc_inc;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;
  logic             ras_hit;
  logic             ras_op;

  assign pc_inc  = pc + STEP;
  assign ras_hit = ret && (cnt_q != '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, next pc and RAS push/pop decisions
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    push    = 1'b0;
    pop     = 1'b0;
    ras_op  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = pc_inc;
        end
      end
      ST_RUN: begin
        if (halt) begin
          // halt freezes everything except a trap redirect
          state_d = ST_HALT;
          if (trap) pc_d = trap_vector;
        end else begin
          ras_op = !stall && !trap;
          // a pop still happens under a branch to keep the stack aligned
          push   = ras_op && call;
          pop    = ras_op && ras_hit;
          if (trap)         pc_d = trap_vector;
          else if (branch)  pc_d = branch_address;
          else if (ras_hit) pc_d = ras_q[top_q];
          else if (!stall)  pc_d = pc_inc;
        end
      end
      ST_HALT: begin
        if (trap) begin
          state_d = ST_RUN;
          pc_d    = trap_vector;
        end else if (!halt && start) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // push+pop together rewrites the top slot in place
    top_d = top_q + PTR_W'(push) - PTR_W'(pop);
    cnt_d = cnt_q;
    if (push && !pop && (cnt_q != DEPTH_C)) cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push)                  cnt_d = cnt_q - CNT_W'(1);
  end

  // Datapath and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_VECTOR - STEP;
      pc_valid  <= 1'b0;
      top_q     <= '0;
      cnt_q     <= '0;
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
    end else begin
      pc        <= pc_d;
      pc_valid  <= (state_d == ST_RUN);
      top_q     <= top_d;
      cnt_q     <= cnt_d;
      ras_empty <= (cnt_d == '0);
      ras_full  <= (cnt_d == DEPTH_C);
    end
  end

  // RAS storage; a push into a full stack overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (!reset && push) ras_q[top_d] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk;
  logic        reset, start, halt, stall, branch, trap, call, ret;
  logic [31:0] branch_address, trap_vector;
  logic [31:0] pc;
  logic        pc_valid, ras_empty, ras_full;
  logic [15:0] pc16;
  logic        pc_valid16, ras_empty16, ras_full16;

  pc_unit dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .branch(branch), .branch_address(branch_address), .trap(trap),
    .trap_vector(trap_vector), .call(call), .ret(ret),
    .pc(pc), .pc_valid(pc_valid), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  // narrow copy driven by the same stimulus: its pc must equal the wide pc mod 2^16
  pc_unit #(.XLEN(16), .RESET_VECTOR(16'h0000)) dut16 (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .branch(branch), .branch_address(branch_address[15:0]), .trap(trap),
    .trap_vector(trap_vector[15:0]), .call(call), .ret(ret),
    .pc(pc16), .pc_valid(pc_valid16), .ras_empty(ras_empty16), .ras_full(ras_full16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        e;
    logic        f;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model: mode 0=idle 1=run 2=halt, stack kept as a queue (back = top)
  logic [31:0] m_pc;
  int          m_mode;
  logic [31:0] stk[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, req);
    end
  endtask

  task automatic model_update();
    logic [31:0] old_pc;
    logic [31:0] tgt;
    bit          has;
    if (reset) begin
      m_pc   = 32'hFFFF_FFFC;
      m_mode = 0;
      stk.delete();
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1;
        m_pc   = m_pc + 32'd4;
      end
    end else if (m_mode == 1) begin
      if (halt) begin
        if (trap) m_pc = trap_vector;
        m_mode = 2;
      end else begin
        old_pc = m_pc;
        has    = (stk.size() > 0);
        tgt    = has ? stk[$] : 32'h0;
        if (trap)            m_pc = trap_vector;
        else if (branch)     m_pc = branch_address;
        else if (ret && has) m_pc = tgt;
        else if (!stall)     m_pc = m_pc + 32'd4;
        if (!stall && !trap) begin
          if (ret && has) void'(stk.pop_back());
          if (call) begin
            stk.push_back(old_pc + 32'd4);
            if (stk.size() > 4) void'(stk.pop_front());
          end
        end
      end
    end else begin
      if (trap) begin
        m_mode = 1;
        m_pc   = trap_vector;
      end else if (!halt && start) begin
        m_mode = 1;
      end
    end
  endtask

  // apply current inputs to the model, queue the expectation, advance to next negedge
  task automatic step();
    exp_t e;
    model_update();
    e.pc = m_pc;
    e.v  = (m_mode == 1);
    e.e  = (stk.size() == 0);
    e.f  = (stk.size() == 4);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic quiet();
    reset = 0; start = 1; halt = 0; stall = 0; branch = 0; trap = 0;
    call = 0; ret = 0; branch_address = 32'h0; trap_vector = 32'h0;
  endtask

  task automatic jump(input logic [31:0] a);
    quiet(); branch = 1; branch_address = a; step();
  endtask

  // monitor: every cycle after the edge, compare DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",        pc,                   e.pc);
        check("pc_valid",  32'(pc_valid),        32'(e.v));
        check("ras_empty", 32'(ras_empty),       32'(e.e));
        check("ras_full",  32'(ras_full),        32'(e.f));
        check("pc16",      32'(pc16),            32'(e.pc[15:0]));
        check("flags16",   {29'h0, pc_valid16, ras_empty16, ras_full16},
                           {29'h0, e.v, e.e, e.f});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset one cycle, then start: FFFFFFFC idle, then 0, 4, 8 ...
    quiet(); start = 0; reset = 1; step();
    quiet(); start = 0; step();
    quiet(); repeat (5) step();               // pc reaches 0x10
    // stall two cycles, then branch under stall
    quiet(); stall = 1; step(); step();
    branch = 1; branch_address = 32'h200; step();
    quiet(); step();
    // trap beats branch and ret; RAS untouched
    quiet(); call = 1; step();
    quiet(); trap = 1; trap_vector = 32'h80; branch = 1; branch_address = 32'h200; ret = 1; step();
    quiet(); ret = 1; step();                 // drains the single entry
    // nested call/return
    jump(32'h40);
    quiet(); call = 1; branch = 1; branch_address = 32'h100; step();
    quiet(); call = 1; branch = 1; branch_address = 32'h300; step();
    quiet(); ret = 1; step();                 // -> 0x104
    jump(32'h48);
    quiet(); ret = 1; step();                 // -> 0x44, empty
    // overflow / underflow with five calls and five returns
    jump(32'h0);
    for (int i = 1; i <= 5; i++) begin
      quiet(); call = 1; branch = 1; branch_address = (i < 5) ? 32'(i * 16) : 32'h500; step();
    end
    for (int i = 0; i < 5; i++) begin
      quiet(); ret = 1; step();
    end
    // halt, hold, trap out of halt, then halt release via start
    jump(32'h20);
    quiet(); halt = 1; step(); step();
    quiet(); halt = 1; trap = 1; trap_vector = 32'h80; step();
    quiet(); step();
    quiet(); halt = 1; step();
    quiet(); step(); step();
    // wrap at the top of the address space
    jump(32'hFFFF_FFF8);
    quiet(); step(); step(); step();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 9) != 0);
      halt   = ($urandom_range(0, 15) == 0);
      stall  = ($urandom_range(0, 5) == 0);
      branch = ($urandom_range(0, 7) == 0);
      trap   = ($urandom_range(0, 24) == 0);
      call   = ($urandom_range(0, 4) == 0);
      ret    = ($urandom_range(0, 4) == 0);
      branch_address = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
      trap_vector    = $urandom & 32'hFFFF_FFFC;
      step();
    end
    quiet();
    repeat (3) @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
